// File: rtl/tile_map_arbiter_pkg.sv
// Shared definitions for the tile-map arbiter: map geometry, tile codes,
// write-FSM state encoding and the nibble merge helper.
// Optional feature macro: MAP_CLEAR_EN (adds the post-reset CLEAR sweep state).
package tile_map_arbiter_pkg;

    localparam int MAP_W         = 20;
    localparam int MAP_H         = 15;
    localparam int ADDR_W        = 9;
    localparam int BYTES_PER_ROW = MAP_W / 2;
    localparam int MAP_BYTES     = MAP_W * MAP_H / 2;

    localparam logic [3:0] TILE_WALL   = 4'h0;
    localparam logic [3:0] TILE_FLOOR  = 4'h1;
    localparam logic [3:0] TILE_PLAYER = 4'h2;
    localparam logic [3:0] CLEAR_TILE  = TILE_FLOOR;

`ifdef MAP_CLEAR_EN
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_MERGE = 3'd2,
        ST_WRITE = 3'd3,
        ST_CLEAR = 3'd4
    } wr_state_e;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_MERGE = 3'd2,
        ST_WRITE = 3'd3
    } wr_state_e;
`endif

    // Replace one nibble of a stored byte; upper selects bits [7:4] (odd x).
    function automatic logic [7:0] merge_nibble(input logic [7:0] old_byte,
                                                input logic       upper,
                                                input logic [3:0] tile);
        logic [7:0] result;
        result = old_byte;
        if (upper) begin
            result[7:4] = tile;
        end else begin
            result[3:0] = tile;
        end
        return result;
    endfunction

endpackage

// File: rtl/tile_map_arbiter_addr_calc.sv
// Maps a tile coordinate onto the packed tile-map BRAM: byte address,
// nibble select (odd columns live in the upper nibble) and an in-range flag.
// Optional feature macro: none.
module tile_addr_calc
    import tile_map_arbiter_pkg::*;
(
    input  logic [4:0]        i_X,
    input  logic [3:0]        i_Y,
    output logic [ADDR_W-1:0] o_Addr,
    output logic              o_Nibble_Sel,
    output logic              o_In_Range
);

    localparam logic [4:0]        MAP_W_X    = 5'(MAP_W);
    localparam logic [3:0]        MAP_H_Y    = 4'(MAP_H);
    localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(BYTES_PER_ROW);

    logic [ADDR_W-1:0] y_ext;
    logic [ADDR_W-1:0] col_pair;

    // Row base plus column pair gives the byte; column LSB picks the nibble.
    always_comb begin
        y_ext        = {{(ADDR_W-4){1'b0}}, i_Y};
        col_pair     = {{(ADDR_W-4){1'b0}}, i_X[4:1]};
        o_Addr       = (y_ext * ROW_STRIDE) + col_pair;
        o_Nibble_Sel = i_X[0];
        o_In_Range   = (i_X < MAP_W_X) && (i_Y < MAP_H_Y);
    end

endmodule

// File: rtl/tile_map_arbiter.sv
// Tile-map BRAM arbiter: shares the single BRAM read port between the
// fixed-latency VGA renderer (always wins) and game-logic single-tile
// writes performed as read-modify-write.
// Optional feature macro: MAP_CLEAR_EN (post-reset sweep filling the map with CLEAR_TILE).
module tile_map_arbiter
    import tile_map_arbiter_pkg::*;
(
    input  logic              i_Clk,
    input  logic              i_Reset,
    input  logic              i_Rd_Req,
    input  logic [4:0]        i_Rd_X,
    input  logic [3:0]        i_Rd_Y,
    output logic              o_Rd_Valid,
    output logic [3:0]        o_Rd_Tile,
    input  logic              i_Wr_Req,
    input  logic [4:0]        i_Wr_X,
    input  logic [3:0]        i_Wr_Y,
    input  logic [3:0]        i_Wr_Tile,
    output logic              o_Wr_Busy,
    output logic              o_Wr_Done,
    output logic [ADDR_W-1:0] o_Bram_Raddr,
    input  logic [7:0]        i_Bram_Rdata,
    output logic [ADDR_W-1:0] o_Bram_Waddr,
    output logic [7:0]        o_Bram_Wdata,
    output logic              o_Bram_We
);

`ifdef MAP_CLEAR_EN
    localparam wr_state_e  RESET_STATE = ST_CLEAR;
    localparam logic [7:0] LAST_CLEAR  = 8'(MAP_BYTES - 1);
`else
    localparam wr_state_e  RESET_STATE = ST_IDLE;
`endif

    logic [ADDR_W-1:0] rd_addr;
    logic              rd_nib;
    logic              rd_in_range;
    logic [ADDR_W-1:0] wr_addr_in;
    logic              wr_nib_in;
    logic              wr_in_range;

    logic              rd_req_p_q, rd_req_p_d;
    logic              rd_nib_p_q, rd_nib_p_d;
    logic              rd_inr_p_q, rd_inr_p_d;
    logic              rd_valid_q, rd_valid_d;
    logic [3:0]        rd_tile_q, rd_tile_d;

    wr_state_e         state_q, state_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              wr_nib_q, wr_nib_d;
    logic [3:0]        wr_tile_q, wr_tile_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [7:0]        wdata_q, wdata_d;
`ifdef MAP_CLEAR_EN
    logic [7:0]        clr_cnt_q, clr_cnt_d;
`endif

    tile_addr_calc u_rd_calc (
        .i_X          (i_Rd_X),
        .i_Y          (i_Rd_Y),
        .o_Addr       (rd_addr),
        .o_Nibble_Sel (rd_nib),
        .o_In_Range   (rd_in_range)
    );

    tile_addr_calc u_wr_calc (
        .i_X          (i_Wr_X),
        .i_Y          (i_Wr_Y),
        .o_Addr       (wr_addr_in),
        .o_Nibble_Sel (wr_nib_in),
        .o_In_Range   (wr_in_range)
    );

    // Renderer owns the read port whenever it asks; otherwise the game address is presented.
    always_comb begin
        o_Bram_Raddr = i_Rd_Req ? rd_addr : wr_addr_q;
    end

    // Two-stage render pipe: carry nibble/range alongside the BRAM latency, then register the tile.
    always_comb begin
        rd_req_p_d = i_Rd_Req;
        rd_nib_p_d = rd_nib;
        rd_inr_p_d = rd_in_range;
        rd_valid_d = rd_req_p_q;
        rd_tile_d  = 4'h0;
        if (rd_req_p_q && rd_inr_p_q) begin
            rd_tile_d = rd_nib_p_q ? i_Bram_Rdata[7:4] : i_Bram_Rdata[3:0];
        end
    end

    // Write FSM next-state: accept, wait for a free read slot, merge the nibble, then pulse the write.
    always_comb begin
        state_d   = state_q;
        wr_addr_d = wr_addr_q;
        wr_nib_d  = wr_nib_q;
        wr_tile_d = wr_tile_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        we_d      = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
`ifdef MAP_CLEAR_EN
        clr_cnt_d = clr_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (i_Wr_Req && !busy_q) begin
                    wr_addr_d = wr_addr_in;
                    wr_nib_d  = wr_nib_in;
                    wr_tile_d = i_Wr_Tile;
                    busy_d    = 1'b1;
                    if (wr_in_range) begin
                        state_d = ST_READ;
                    end else begin
                        state_d = ST_WRITE;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_READ: begin
                busy_d = 1'b1;
                if (!i_Rd_Req) begin
                    state_d = ST_MERGE;
                end
            end
            ST_MERGE: begin
                busy_d  = 1'b1;
                we_d    = 1'b1;
                done_d  = 1'b1;
                waddr_d = wr_addr_q;
                wdata_d = merge_nibble(i_Bram_Rdata, wr_nib_q, wr_tile_q);
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
            end
`ifdef MAP_CLEAR_EN
            ST_CLEAR: begin
                busy_d    = 1'b1;
                we_d      = 1'b1;
                waddr_d   = ADDR_W'(clr_cnt_q);
                wdata_d   = {CLEAR_TILE, CLEAR_TILE};
                clr_cnt_d = clr_cnt_q + 8'd1;
                if (clr_cnt_q == LAST_CLEAR) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // All state registers; synchronous reset drops any pending write and flushes the render pipe.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            rd_req_p_q <= 1'b0;
            rd_nib_p_q <= 1'b0;
            rd_inr_p_q <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_tile_q  <= 4'h0;
            state_q    <= RESET_STATE;
            wr_addr_q  <= '0;
            wr_nib_q   <= 1'b0;
            wr_tile_q  <= 4'h0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= 8'h00;
`ifdef MAP_CLEAR_EN
            clr_cnt_q  <= 8'd0;
`endif
        end else begin
            rd_req_p_q <= rd_req_p_d;
            rd_nib_p_q <= rd_nib_p_d;
            rd_inr_p_q <= rd_inr_p_d;
            rd_valid_q <= rd_valid_d;
            rd_tile_q  <= rd_tile_d;
            state_q    <= state_d;
            wr_addr_q  <= wr_addr_d;
            wr_nib_q   <= wr_nib_d;
            wr_tile_q  <= wr_tile_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
`ifdef MAP_CLEAR_EN
            clr_cnt_q  <= clr_cnt_d;
`endif
        end
    end

    // Registered outputs straight from the flops.
    always_comb begin
        o_Rd_Valid   = rd_valid_q;
        o_Rd_Tile    = rd_tile_q;
        o_Wr_Busy    = busy_q;
        o_Wr_Done    = done_q;
        o_Bram_We    = we_q;
        o_Bram_Waddr = waddr_q;
        o_Bram_Wdata = wdata_q;
    end

endmodule

// File: tb/tb_tile_map_arbiter.sv
// Self-checking bench for tile_map_arbiter (default build, MAP_CLEAR_EN undefined).
// The bench emulates the BRAM and keeps a tile-level map model plus a
// timing model of the write handshake derived from the arbitration rules.
module tb_tile_map_arbiter;

    localparam int W = 20;
    localparam int H = 15;

    logic       i_Clk = 1'b0;
    logic       i_Reset = 1'b1;
    logic       i_Rd_Req = 1'b0;
    logic [4:0] i_Rd_X = '0;
    logic [3:0] i_Rd_Y = '0;
    logic       o_Rd_Valid;
    logic [3:0] o_Rd_Tile;
    logic       i_Wr_Req = 1'b0;
    logic [4:0] i_Wr_X = '0;
    logic [3:0] i_Wr_Y = '0;
    logic [3:0] i_Wr_Tile = '0;
    logic       o_Wr_Busy;
    logic       o_Wr_Done;
    logic [8:0] o_Bram_Raddr;
    logic [7:0] bram_rdata;
    logic [8:0] o_Bram_Waddr;
    logic [7:0] o_Bram_Wdata;
    logic       o_Bram_We;

    logic [7:0] bram [0:511];
    logic [7:0] init_img [0:511];
    logic       load_bram = 1'b0;

    logic [3:0] tiles [0:W-1][0:H-1];

    typedef struct {
        int         due;
        logic [3:0] tile;
    } rexp_t;
    rexp_t rq[$];

    int cyc = 0;
    int n_cmp = 0;
    int n_fail = 0;
    bit checking = 1'b0;

    int m_busy_from = 0;
    int m_busy_until = -1;
    bit m_read_pending = 1'b0;
    int m_done_cycle = -1;
    bit m_oor = 1'b0;
    bit m_reset_pending = 1'b0;
    int m_tx = 0;
    int m_ty = 0;
    logic [3:0] m_tt = 4'h0;

    always #20 i_Clk = ~i_Clk;

    tile_map_arbiter dut (
        .i_Clk        (i_Clk),
        .i_Reset      (i_Reset),
        .i_Rd_Req     (i_Rd_Req),
        .i_Rd_X       (i_Rd_X),
        .i_Rd_Y       (i_Rd_Y),
        .o_Rd_Valid   (o_Rd_Valid),
        .o_Rd_Tile    (o_Rd_Tile),
        .i_Wr_Req     (i_Wr_Req),
        .i_Wr_X       (i_Wr_X),
        .i_Wr_Y       (i_Wr_Y),
        .i_Wr_Tile    (i_Wr_Tile),
        .o_Wr_Busy    (o_Wr_Busy),
        .o_Wr_Done    (o_Wr_Done),
        .o_Bram_Raddr (o_Bram_Raddr),
        .i_Bram_Rdata (bram_rdata),
        .o_Bram_Waddr (o_Bram_Waddr),
        .o_Bram_Wdata (o_Bram_Wdata),
        .o_Bram_We    (o_Bram_We)
    );

    // BRAM stand-in: one-cycle registered read, write on We, optional image load.
    always @(posedge i_Clk) begin
        bram_rdata <= bram[o_Bram_Raddr];
        if (load_bram) begin
            for (int k = 0; k < 512; k++) bram[k] <= init_img[k];
        end else if (o_Bram_We) begin
            bram[o_Bram_Waddr] <= o_Bram_Wdata;
        end
    end

    function automatic bit inMap(input int x, input int y);
        return (x < W) && (y < H);
    endfunction

    function automatic bit busyAt(input int c);
        return (c >= m_busy_from) && (m_read_pending || (c <= m_busy_until));
    endfunction

    task automatic expectEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Per-cycle check of everything the DUT presents in the current cycle.
    task automatic checkOutput();
        bit done_exp;
        bit we_exp;
        logic [3:0] lo;
        logic [3:0] hi;
        if (checking) begin
            if (rq.size() > 0 && rq[0].due == cyc) begin
                expectEq("rd_valid", {31'd0, o_Rd_Valid}, 32'd1);
                expectEq("rd_tile", {28'd0, o_Rd_Tile}, {28'd0, rq[0].tile});
                void'(rq.pop_front());
            end else begin
                expectEq("rd_valid_idle", {31'd0, o_Rd_Valid}, 32'd0);
            end
            expectEq("wr_busy", {31'd0, o_Wr_Busy}, {31'd0, busyAt(cyc)});
            done_exp = (cyc == m_done_cycle);
            we_exp   = done_exp && !m_oor;
            expectEq("wr_done", {31'd0, o_Wr_Done}, {31'd0, done_exp});
            expectEq("bram_we", {31'd0, o_Bram_We}, {31'd0, we_exp});
            if (we_exp) begin
                lo = tiles[m_tx & ~1][m_ty];
                hi = tiles[m_tx | 1][m_ty];
                if (m_tx % 2 == 1) hi = m_tt;
                else lo = m_tt;
                expectEq("bram_waddr", {23'd0, o_Bram_Waddr}, 32'(m_ty * (W / 2) + m_tx / 2));
                expectEq("bram_wdata", {24'd0, o_Bram_Wdata}, {24'd0, hi, lo});
                tiles[m_tx][m_ty] = m_tt;
            end
        end
        if (m_reset_pending) begin
            m_read_pending  = 1'b0;
            m_done_cycle    = -1;
            m_busy_until    = -1;
            m_busy_from     = 0;
            m_reset_pending = 1'b0;
            rq.delete();
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, update the models, check outputs.
    task automatic applyStimulus(input logic rst, input logic rd, input logic [4:0] rx,
                                 input logic [3:0] ry, input logic wr, input logic [4:0] wx,
                                 input logic [3:0] wy, input logic [3:0] wt);
        bit busy_now;
        rexp_t e;
        @(negedge i_Clk);
        cyc++;
        i_Reset   = rst;
        i_Rd_Req  = rd;
        i_Rd_X    = rx;
        i_Rd_Y    = ry;
        i_Wr_Req  = wr;
        i_Wr_X    = wx;
        i_Wr_Y    = wy;
        i_Wr_Tile = wt;
        if (rd && !rst) begin
            e.due  = cyc + 2;
            e.tile = inMap(int'(rx), int'(ry)) ? tiles[rx][ry] : 4'h0;
            rq.push_back(e);
        end
        busy_now = busyAt(cyc);
        if (!rst) begin
            if (m_read_pending && cyc >= m_busy_from && !rd) begin
                m_read_pending = 1'b0;
                m_done_cycle   = cyc + 2;
                m_busy_until   = cyc + 2;
            end else if (!busy_now && wr) begin
                m_busy_from = cyc + 1;
                m_tx = int'(wx);
                m_ty = int'(wy);
                m_tt = wt;
                if (inMap(m_tx, m_ty)) begin
                    m_oor = 1'b0;
                    m_read_pending = 1'b1;
                end else begin
                    m_oor = 1'b1;
                    m_done_cycle = cyc + 1;
                    m_busy_until = cyc + 1;
                end
            end
        end else begin
            m_reset_pending = 1'b1;
        end
        checkOutput();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 5'd0, 4'd0, 1'b0, 5'd0, 4'd0, 4'd0);
    endtask

    initial begin
        logic [4:0] rx;
        logic [3:0] ry;
        logic [4:0] wx;
        logic [3:0] wy;
        logic [3:0] wt;
        logic       rd;
        logic       wr;
        logic       rst;

        // Map image: random tiles with a few fixed cells for the directed steps.
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                tiles[x][y] = 4'($urandom_range(0, 15));
        tiles[4][3] = 4'h0;
        tiles[5][3] = 4'h2;
        for (int k = 0; k < 512; k++) init_img[k] = 8'($urandom_range(0, 255));
        for (int y = 0; y < H; y++)
            for (int xp = 0; xp < W / 2; xp++)
                init_img[y * (W / 2) + xp] = {tiles[2 * xp + 1][y], tiles[2 * xp][y]};
        load_bram = 1'b1;

        // Power-on reset, then check the reset state.
        applyStimulus(1'b1, 1'b0, 5'd0, 4'd0, 1'b0, 5'd0, 4'd0, 4'd0);
        applyStimulus(1'b1, 1'b0, 5'd0, 4'd0, 1'b0, 5'd0, 4'd0, 4'd0);
        load_bram = 1'b0;
        applyStimulus(1'b1, 1'b0, 5'd0, 4'd0, 1'b0, 5'd0, 4'd0, 4'd0);
        checking = 1'b1;
        idle(1);
        expectEq("reset_rd_tile", {28'd0, o_Rd_Tile}, 32'd0);
        expectEq("reset_waddr", {23'd0, o_Bram_Waddr}, 32'd0);
        expectEq("reset_wdata", {24'd0, o_Bram_Wdata}, 32'd0);

        // Single render read of (5,3): tile 2 two cycles later.
        applyStimulus(1'b0, 1'b1, 5'd5, 4'd3, 1'b0, 5'd0, 4'd0, 4'd0);
        idle(3);

        // Quiet write (4,3)=2.
        applyStimulus(1'b0, 1'b0, 5'd0, 4'd0, 1'b1, 5'd4, 4'd3, 4'h2);
        idle(5);

        // Write (5,3)=7 while the renderer holds the port for 6 cycles.
        applyStimulus(1'b0, 1'b1, 5'd0, 4'd0, 1'b1, 5'd5, 4'd3, 4'h7);
        for (int i = 1; i < 6; i++)
            applyStimulus(1'b0, 1'b1, 5'(i + 2), 4'd3, 1'b0, 5'd0, 4'd0, 4'd0);
        idle(4);

        // Out-of-range write with an out-of-range render read in the same cycle.
        applyStimulus(1'b0, 1'b1, 5'd20, 4'd0, 1'b1, 5'd20, 4'd3, 4'h2);
        idle(3);

        // Write request held high: one accept per completed write.
        for (int i = 0; i < 6; i++)
            applyStimulus(1'b0, 1'b0, 5'd0, 4'd0, 1'b1, 5'd9, 4'd14, 4'(i + 3));
        idle(5);

        // Reset while the write sits in MERGE, then a clean write.
        applyStimulus(1'b0, 1'b0, 5'd0, 4'd0, 1'b1, 5'd2, 4'd5, 4'h9);
        applyStimulus(1'b0, 1'b0, 5'd0, 4'd0, 1'b0, 5'd0, 4'd0, 4'd0);
        applyStimulus(1'b1, 1'b0, 5'd0, 4'd0, 1'b0, 5'd0, 4'd0, 4'd0);
        idle(1);
        expectEq("midreset_waddr", {23'd0, o_Bram_Waddr}, 32'd0);
        expectEq("midreset_wdata", {24'd0, o_Bram_Wdata}, 32'd0);
        applyStimulus(1'b0, 1'b0, 5'd0, 4'd0, 1'b1, 5'd2, 4'd5, 4'h9);
        idle(5);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            rd  = ($urandom_range(0, 9) < 7);
            rx  = 5'($urandom_range(0, 23));
            ry  = 4'($urandom_range(0, 15));
            wr  = ($urandom_range(0, 3) == 0);
            wx  = 5'($urandom_range(0, 21));
            wy  = 4'($urandom_range(0, 15));
            wt  = 4'($urandom_range(0, 15));
            applyStimulus(rst, rd, rx, ry, wr, wx, wy, wt);
        end
        idle(8);

        // Read back the whole map.
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                applyStimulus(1'b0, 1'b1, 5'(x), 4'(y), 1'b0, 5'd0, 4'd0, 4'd0);
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
